// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: 4-entry {div, dwell} LED blink-rate sequencer feeding a blink counter.
// Define LED_SEQ_LOOP_EN to repeat the sequence until stop_i instead of ending with done_o.
module led_seq_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk100,
  input  logic               rstn,
  input  logic               cfg_wr_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [DWELL_W+4:0] cfg_data_i,
  output logic               cfg_rdy_o,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               led_int_i,
  output logic [4:0]         div_o,
  output logic               wren_o,
  output logic               busy_o,
  output logic [1:0]         idx_o,
  output logic               done_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, ADV} state_t;
  localparam logic [DWELL_W-1:0] one = {{(DWELL_W-1){1'b0}}, 1'b1};
  state_t state, state_nxt;
  logic [4:0] div_tab [4];
  logic [DWELL_W-1:0] dwell_tab [4];
  logic [DWELL_W-1:0] cnt;
  logic [1:0] idx, idx_nxt;
  logic ld, done_nxt, last;
  assign cfg_rdy_o = state == IDLE;
  assign busy_o = !cfg_rdy_o;
  assign idx_o = idx;
  // A zero dwell in the following entry marks the end of a short sequence.
  assign last = (idx == 2'd3) || (dwell_tab[idx + 2'd1] == '0);
  always_ff @(posedge clk100 or negedge rstn)
    if (!rstn) begin
      div_tab <= '{default: '0};
      dwell_tab <= '{default: '0};
    end else if (cfg_wr_i && cfg_rdy_o) begin
      div_tab[cfg_addr_i] <= cfg_data_i[4:0];
      dwell_tab[cfg_addr_i] <= cfg_data_i[DWELL_W+4:5];
    end
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    ld = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE: if (start_i && !stop_i) begin
        if (dwell_tab[0] == '0) done_nxt = 1'b1;
        else begin
          state_nxt = LOAD;
          ld = 1'b1;
        end
      end
      LOAD: state_nxt = stop_i ? IDLE : RUN;
      RUN: state_nxt = stop_i ? IDLE : (led_int_i && cnt == one) ? ADV : RUN;
      ADV: if (stop_i) state_nxt = IDLE;
      else if (!last) begin
        idx_nxt = idx + 2'd1;
        state_nxt = LOAD;
        ld = 1'b1;
      end else begin
`ifdef LED_SEQ_LOOP_EN
        idx_nxt = 2'd0;
        state_nxt = LOAD;
        ld = 1'b1;
`else
        state_nxt = IDLE;
        done_nxt = 1'b1;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE) idx_nxt = 2'd0;
  end
  // Outputs are registered on entry to LOAD so div_o and wren_o appear one cycle after start.
  always_ff @(posedge clk100 or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      idx <= 2'd0;
      cnt <= '0;
      div_o <= 5'd0;
      wren_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      wren_o <= ld;
      done_o <= done_nxt;
      div_o <= ld ? div_tab[idx_nxt] : (state_nxt == IDLE) ? 5'd0 : div_o;
      cnt <= ld ? dwell_tab[idx_nxt] : (state_nxt == IDLE) ? '0 :
             (state == RUN && led_int_i && cnt > one) ? cnt - one : cnt;
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: vector table for the basic sequence plus directed stop/busy-write/reset cases.
module tb_led_seq_ctrl;
  localparam int DW = 8;
  logic clk100 = 1'b0, rstn = 1'b0, cfg_wr_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, led_int_i = 1'b0;
  logic [1:0] cfg_addr_i = '0;
  logic [DW+4:0] cfg_data_i = '0;
  logic cfg_rdy_o, wren_o, busy_o, done_o;
  logic [4:0] div_o;
  logic [1:0] idx_o;
  int checks = 0, errors = 0;
  typedef struct {int st, sp, led, wren, div, busy, done, idx;} vec_t;
  vec_t v[11];

  led_seq_ctrl #(.DWELL_W(DW)) dut (
    .clk100(clk100), .rstn(rstn), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .cfg_rdy_o(cfg_rdy_o), .start_i(start_i), .stop_i(stop_i),
    .led_int_i(led_int_i), .div_o(div_o), .wren_o(wren_o), .busy_o(busy_o),
    .idx_o(idx_o), .done_o(done_o)
  );

  always #5 clk100 = ~clk100;

  task automatic tick;
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic outs(input string t, input int wren, input int div, input int busy, input int done, input int idx);
    chk({t, ".wren"}, int'(wren_o), wren);
    chk({t, ".div"}, int'(div_o), div);
    chk({t, ".busy"}, int'(busy_o), busy);
    chk({t, ".done"}, int'(done_o), done);
    chk({t, ".idx"}, int'(idx_o), idx);
  endtask

  task automatic wr(input int a, input int d, input int dw);
    cfg_wr_i = 1'b1;
    cfg_addr_i = a[1:0];
    cfg_data_i = {dw[DW-1:0], d[4:0]};
    tick;
    cfg_wr_i = 1'b0;
  endtask

  task automatic leds(input int n);
    repeat (n) begin
      led_int_i = 1'b1;
      tick;
    end
    led_int_i = 1'b0;
  endtask

  task automatic stop_cycle;
    stop_i = 1'b1;
    tick;
    stop_i = 1'b0;
  endtask

  initial begin
    v[0] = '{1, 0, 0, 1, 2, 1, 0, 0};
    v[1] = '{0, 0, 0, 0, 2, 1, 0, 0};
    v[2] = '{0, 0, 1, 0, 2, 1, 0, 0};
    v[3] = '{0, 0, 1, 0, 2, 1, 0, 0};
    v[4] = '{0, 0, 1, 0, 2, 1, 0, 0};
    v[5] = '{0, 0, 0, 1, 4, 1, 0, 1};
    v[6] = '{0, 0, 0, 0, 4, 1, 0, 1};
    v[7] = '{0, 0, 1, 0, 4, 1, 0, 1};
    v[8] = '{0, 0, 1, 0, 4, 1, 0, 1};
`ifdef LED_SEQ_LOOP_EN
    v[9] = '{0, 0, 0, 1, 2, 1, 0, 0};
    v[10] = '{0, 0, 0, 0, 2, 1, 0, 0};
`else
    v[9] = '{0, 0, 0, 0, 0, 0, 1, 0};
    v[10] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    tick;
    tick;
    outs("rst", 0, 0, 0, 0, 0);
    chk("rst.rdy", int'(cfg_rdy_o), 1);
    rstn = 1'b1;
    tick;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    outs("e0zero", 0, 0, 0, 1, 0);
    tick;
    chk("e0zero.once", int'(done_o), 0);
    wr(0, 2, 3);
    wr(1, 4, 2);
    for (int i = 0; i < 11; i++) begin
      start_i = v[i].st != 0;
      stop_i = v[i].sp != 0;
      led_int_i = v[i].led != 0;
      tick;
      outs($sformatf("vec%0d", i), v[i].wren, v[i].div, v[i].busy, v[i].done, v[i].idx);
    end
    start_i = 1'b0;
    led_int_i = 1'b0;
    stop_cycle;
    outs("idle", 0, 0, 0, 0, 0);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick;
    leds(2);
    led_int_i = 1'b1;
    stop_i = 1'b1;
    tick;
    led_int_i = 1'b0;
    stop_i = 1'b0;
    outs("stop", 0, 0, 0, 0, 0);
    tick;
    outs("stop.after", 0, 0, 0, 0, 0);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("busy.rdy", int'(cfg_rdy_o), 0);
    wr(1, 9, 5);
    leds(3);
    tick;
    outs("busywr.e1", 1, 4, 1, 0, 1);
    tick;
    leds(2);
    tick;
`ifdef LED_SEQ_LOOP_EN
    outs("busywr.wrap", 1, 2, 1, 0, 0);
`else
    outs("busywr.end", 0, 0, 0, 1, 0);
`endif
    stop_cycle;
    wr(0, 1, 1);
    wr(1, 2, 1);
    wr(2, 3, 1);
    wr(3, 4, 1);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int e = 0; e < 4; e++) begin
      outs($sformatf("dw1.e%0d", e), 1, e + 1, 1, 0, e);
      tick;
      leds(1);
      tick;
    end
`ifdef LED_SEQ_LOOP_EN
    outs("dw1.wrap", 1, 1, 1, 0, 0);
`else
    outs("dw1.end", 0, 0, 0, 1, 0);
`endif
    stop_cycle;
    start_i = 1'b1;
    stop_i = 1'b1;
    tick;
    start_i = 1'b0;
    stop_i = 1'b0;
    outs("ststp", 0, 0, 0, 0, 0);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick;
    chk("pre.div", int'(div_o), 1);
    chk("pre.busy", int'(busy_o), 1);
    #2;
    rstn = 1'b0;
    #1;
    outs("arst", 0, 0, 0, 0, 0);
    tick;
    rstn = 1'b1;
    tick;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    outs("arst.e0", 0, 0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
